// File: rtl/branch_predict_btb_if.sv
// Lookup/update bus between the fetch/execute stages and the branch target buffer.
// The master side is the core pipeline (IF drives lookup_pc, EX drives upd_*);
// the slave side is the BTB itself.
// Optional macro BTB_STATS_EN adds upd_pred_taken and the stat_* counters.
interface branch_predict_btb_if #(
    parameter int ADDR_W = 32
);
    logic              [ADDR_W-1:0] lookup_pc;
    logic                           pred_hit;
    logic                           pred_taken;
    logic              [ADDR_W-1:0] pred_target;
    logic                           upd_valid;
    logic              [ADDR_W-1:0] upd_pc;
    logic                           upd_taken;
    logic              [ADDR_W-1:0] upd_target;
`ifdef BTB_STATS_EN
    logic                           upd_pred_taken;
    logic              [31:0]       stat_branches;
    logic              [31:0]       stat_mispred;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
        input  pred_hit, pred_taken, pred_target, stat_branches, stat_mispred
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
        output pred_hit, pred_taken, pred_target, stat_branches, stat_mispred
    );
`else
    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  pred_hit, pred_taken, pred_target
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
        output pred_hit, pred_taken, pred_target
    );
`endif
endinterface

// File: rtl/branch_predict_btb.sv
// Direct-mapped, tagged branch target buffer with saturating direction counters.
// Lookup is combinational off the current array contents (no write bypass);
// EX updates are written on the rising clock edge.
// Optional macro BTB_STATS_EN adds branch / misprediction counters.
module branch_predict_btb #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    branch_predict_btb_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    // Only valid bits are reset; payload fields are don't-care until allocated.
    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [ADDR_W-1:0]  target_mem [ENTRIES];
    logic [CNT_W-1:0]   cnt_mem    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    // Byte offset within the instruction word never selects an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

    assign lk_idx = bus.lookup_pc[IDX_W+1:2];
    assign lk_tag = bus.lookup_pc[ADDR_W-1:IDX_W+2];
    assign up_idx = bus.upd_pc[IDX_W+1:2];
    assign up_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];

    // A cleared valid bit masks the never-written tag/target/cnt, so misses are clean zeros.
    assign lk_hit          = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign up_hit          = valid[up_idx] && (tag_mem[up_idx] == up_tag);
    assign bus.pred_hit    = lk_hit;
    assign bus.pred_taken  = lk_hit && cnt_mem[lk_idx][CNT_W-1];
    assign bus.pred_target = lk_hit ? target_mem[lk_idx] : '0;

    // Valid bits: cleared by reset, set when a taken branch misses and allocates.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (bus.upd_valid && bus.upd_taken && !up_hit) begin
            valid[up_idx] <= 1'b1;
        end
    end

    // Entry payload: train the counter on a hit, replace the whole entry on a taken miss.
    always_ff @(posedge clk) begin
        if (!reset && bus.upd_valid) begin
            if (up_hit) begin
                if (bus.upd_taken) begin
                    cnt_mem[up_idx]    <= cnt_inc(cnt_mem[up_idx]);
                    target_mem[up_idx] <= bus.upd_target;
                end else begin
                    cnt_mem[up_idx]    <= cnt_dec(cnt_mem[up_idx]);
                end
            end else if (bus.upd_taken) begin
                tag_mem[up_idx]    <= up_tag;
                target_mem[up_idx] <= bus.upd_target;
                cnt_mem[up_idx]    <= CNT_WEAK;
            end
        end
    end

`ifdef BTB_STATS_EN
    function automatic logic [31:0] stat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] branches;
    logic [31:0] mispred;

    // Resolved-branch and misprediction counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            branches <= '0;
            mispred  <= '0;
        end else if (bus.upd_valid) begin
            branches <= stat_inc(branches);
            if (bus.upd_pred_taken != bus.upd_taken) begin
                mispred <= stat_inc(mispred);
            end
        end
    end

    assign bus.stat_branches = branches;
    assign bus.stat_mispred  = mispred;
`endif
endmodule

// File: tb/tb_branch_predict_btb.sv
// Self-checking bench for branch_predict_btb: directed test-plan steps followed
// by randomized traffic, all compared against a per-entry reference model.
module tb_branch_predict_btb;
    localparam int ENTRIES  = 16;
    localparam int ADDR_W   = 32;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int CNT_HALF = 1 << (CNT_W - 1);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    branch_predict_btb_if #(.ADDR_W(ADDR_W)) bus ();

    branch_predict_btb #(
        .ENTRIES(ENTRIES),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: one record per set, fields held as plain integers.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    longint unsigned m_br = 0;
    longint unsigned m_mp = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_lookup(input string name);
        int   i;
        bit   h;
        i = idx_of(bus.lookup_pc);
        h = m_valid[i] && (m_tag[i] == tag_of(bus.lookup_pc));
        check({name, "_hit"},    32'(bus.pred_hit),   32'(h));
        check({name, "_taken"},  32'(bus.pred_taken), 32'(h && (m_cnt[i] >= CNT_HALF)));
        check({name, "_target"}, bus.pred_target,     h ? m_tgt[i] : 32'h0);
`ifdef BTB_STATS_EN
        check({name, "_stat_br"}, bus.stat_branches, 32'(m_br));
        check({name, "_stat_mp"}, bus.stat_mispred,  32'(m_mp));
`endif
    endtask

    // Apply the clock-edge rules to the model using the inputs held this cycle.
    task automatic model_clock();
        int i;
        bit h;
        if (reset) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
            m_br = 0;
            m_mp = 0;
        end else if (bus.upd_valid) begin
            i = idx_of(bus.upd_pc);
            h = m_valid[i] && (m_tag[i] == tag_of(bus.upd_pc));
            if (h && bus.upd_taken) begin
                m_cnt[i] = (m_cnt[i] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[i] + 1;
                m_tgt[i] = bus.upd_target;
            end else if (h) begin
                m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
            end else if (bus.upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(bus.upd_pc);
                m_tgt[i]   = bus.upd_target;
                m_cnt[i]   = CNT_HALF;
            end
`ifdef BTB_STATS_EN
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (bus.upd_pred_taken != bus.upd_taken && m_mp < 64'hFFFF_FFFF) m_mp++;
`endif
        end
    endtask

    task automatic drive(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                         input bit ut, input logic [31:0] utgt, input bit pt, input bit rst_in);
        reset          = rst_in;
        bus.lookup_pc  = lpc;
        bus.upd_valid  = uv;
        bus.upd_pc     = upc;
        bus.upd_taken  = ut;
        bus.upd_target = utgt;
`ifdef BTB_STATS_EN
        bus.upd_pred_taken = pt;
`else
        if (pt) begin end
`endif
    endtask

    // One cycle: drive at negedge, check pre-update lookup, then clock the model.
    task automatic step(input string name, input logic [31:0] lpc, input bit uv,
                        input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                        input bit pt, input bit rst_in);
        @(negedge clk);
        drive(lpc, uv, upc, ut, utgt, pt, rst_in);
        #1 check_lookup(name);
        @(posedge clk);
        model_clock();
    endtask

    // Idle lookup with explicit expected values on top of the model comparison.
    task automatic peek(input string name, input logic [31:0] lpc, input bit eh,
                        input bit et, input logic [31:0] etgt);
        @(negedge clk);
        drive(lpc, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        #1;
        check({name, "_hit_c"},    32'(bus.pred_hit),   32'(eh));
        check({name, "_taken_c"},  32'(bus.pred_taken), 32'(et));
        check({name, "_target_c"}, bus.pred_target,     etgt);
        check_lookup(name);
        @(posedge clk);
        model_clock();
    endtask

    initial begin
        logic [31:0] lpc, upc;
        for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 1'b0;
            m_tag[k]   = '0;
            m_tgt[k]   = '0;
            m_cnt[k]   = 0;
        end

        // Reset for two cycles; contents are undefined beforehand, so no check yet.
        repeat (2) begin
            @(negedge clk);
            drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            @(posedge clk);
            model_clock();
        end
        peek("after_reset", 32'h40, 1'b0, 1'b0, 32'h0);

        // Allocate 0x40 as weakly taken.
        step("alloc_cyc", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
        peek("alloc", 32'h40, 1'b1, 1'b1, 32'h100);

        // Counter walk down and saturate at zero.
        step("nt1_cyc", 32'h0, 1'b1, 32'h40, 1'b0, 32'hBAD0, 1'b0, 1'b0);
        peek("nt1", 32'h40, 1'b1, 1'b0, 32'h100);
        step("nt2_cyc", 32'h0, 1'b1, 32'h40, 1'b0, 32'hBAD0, 1'b0, 1'b0);
        peek("nt2", 32'h40, 1'b1, 1'b0, 32'h100);
        step("nt3_cyc", 32'h0, 1'b1, 32'h40, 1'b0, 32'hBAD0, 1'b0, 1'b0);
        peek("nt3", 32'h40, 1'b1, 1'b0, 32'h100);

        // Counter walk up: 1, 2, 3, 3.
        step("t1_cyc", 32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
        peek("t1", 32'h40, 1'b1, 1'b0, 32'h100);
        step("t2_cyc", 32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
        peek("t2", 32'h40, 1'b1, 1'b1, 32'h100);
        step("t3_cyc", 32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
        peek("t3", 32'h40, 1'b1, 1'b1, 32'h100);
        step("t4_cyc", 32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
        peek("t4", 32'h40, 1'b1, 1'b1, 32'h100);
        // Saturated at max: a single not-taken must keep the prediction taken.
        step("sat_nt_cyc", 32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        peek("sat_nt", 32'h40, 1'b1, 1'b1, 32'h100);

        // No allocation on a not-taken miss.
        step("nt_miss_cyc", 32'h0, 1'b1, 32'h80, 1'b0, 32'h900, 1'b0, 1'b0);
        peek("nt_miss", 32'h80, 1'b0, 1'b0, 32'h0);

        // Alias at index 0 with a new tag replaces the old entry.
        step("alias_cyc", 32'h0, 1'b1, 32'h440, 1'b1, 32'h300, 1'b0, 1'b0);
        peek("alias_old", 32'h40, 1'b0, 1'b0, 32'h0);
        peek("alias_new", 32'h440, 1'b1, 1'b1, 32'h300);

        // Reinstall 0x40, then look up and update it in the same cycle.
        step("reinst_cyc", 32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
        @(negedge clk);
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 1'b0);
        #1;
        check("same_cyc_old_target", bus.pred_target, 32'h100);
        check_lookup("same_cyc");
        @(posedge clk);
        model_clock();
        peek("same_cyc_next", 32'h40, 1'b1, 1'b1, 32'h200);

        // Reset wins over a simultaneous update.
        step("rst_upd_cyc", 32'h40, 1'b1, 32'h80, 1'b1, 32'h500, 1'b1, 1'b1);
        peek("rst_upd_40", 32'h40, 1'b0, 1'b0, 32'h0);
        peek("rst_upd_80", 32'h80, 1'b0, 1'b0, 32'h0);

`ifdef BTB_STATS_EN
        step("st1", 32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
        step("st2", 32'h0, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 1'b0);
        step("st3", 32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
        @(negedge clk);
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("stat_branches_3", bus.stat_branches, 32'd3);
        check("stat_mispred_1", bus.stat_mispred, 32'd1);
        @(posedge clk);
        model_clock();
        step("st_rst", 32'h0, 1'b1, 32'h40, 1'b1, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("stat_branches_rst", bus.stat_branches, 32'd0);
        check("stat_mispred_rst", bus.stat_mispred, 32'd0);
        @(posedge clk);
        model_clock();
`endif

        // Randomized traffic over 4 tags x 16 sets so hits and aliases are frequent.
        for (int n = 0; n < 400; n++) begin
            lpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            upc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            step("rand", lpc, ($urandom_range(0, 3) != 0), upc, 1'($urandom), $urandom,
                 1'($urandom), ($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
